// File: rtl/riscv_gpio_pkg.sv
// Shared constants and register decode for the memory-mapped GPIO input port.
package riscv_gpio_pkg;

  localparam int GPIO_BUS_W = 32;

  localparam logic [3:0] GPIO_DATA_OFS  = 4'h0;
  localparam logic [3:0] GPIO_RISE_OFS  = 4'h4;
  localparam logic [3:0] GPIO_FALL_OFS  = 4'h8;
  localparam logic [3:0] GPIO_IRQEN_OFS = 4'hC;

  typedef enum logic [2:0] {
    REG_DATA,
    REG_RISE,
    REG_FALL,
    REG_IRQEN,
    REG_NONE
  } gpio_reg_e;

  // Word-aligned decode; the byte-lane bits of the offset do not select anything.
  function automatic gpio_reg_e gpio_decode(input logic [3:0] addr);
    logic [3:0] ofs;
    gpio_reg_e  sel;
    ofs = {addr[3:2], 2'b00};
    case (ofs)
      GPIO_DATA_OFS:  sel = REG_DATA;
      GPIO_RISE_OFS:  sel = REG_RISE;
      GPIO_FALL_OFS:  sel = REG_FALL;
      GPIO_IRQEN_OFS: sel = REG_IRQEN;
      default:        sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO input channel: synchroniser chain, optional debounce filter
// (GPIO_DEBOUNCE_EN), stable level flop and rise/fall change pulses.
module gpio_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("gpio_debounce: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("gpio_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  logic                   stable_q;
  logic                   stable_d;

  // NOTE: flops are written with <= so every register samples its pre-edge
  // inputs; blocking here would collapse the synchroniser into one stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end
  end

  assign sync_bit = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_bit != stable_q) begin
      // Counter tops out at CNT_LAST and then resets, so it never wraps.
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_bit;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end
`else
  always_comb begin
    stable_d = sync_bit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= 1'b0;
    end else begin
      stable_q <= stable_d;
    end
  end
`endif

  // Pulses coincide with the edge that updates the stable level.
  assign stable_o = stable_q;
  assign rise_o   = ~stable_q &  stable_d;
  assign fall_o   =  stable_q & ~stable_d;

endmodule

// File: rtl/riscv_gpio_in_port.sv
// Memory-mapped GPIO input peripheral: per-channel filtering, sticky edge
// capture (W1C), interrupt enable and a registered read port.
// Debounce filter is built only when GPIO_DEBOUNCE_EN is defined.
module riscv_gpio_in_port
  import riscv_gpio_pkg::*;
#(
  parameter int WIDTH           = 9,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      gpio_port_in,
  input  logic [3:0]            addr,
  input  logic                  we,
  input  logic                  re,
  input  logic [GPIO_BUS_W-1:0] wdata,
  output logic [GPIO_BUS_W-1:0] rdata,
  output logic                  rvalid,
  output logic                  irq
);

  if (WIDTH < 1 || WIDTH > GPIO_BUS_W) begin : g_bad_width
    $error("riscv_gpio_in_port: WIDTH must be in 1..32");
  end

  logic [WIDTH-1:0]      stable;
  logic [WIDTH-1:0]      rise_set;
  logic [WIDTH-1:0]      fall_set;

  logic [WIDTH-1:0]      rise_q,   rise_d;
  logic [WIDTH-1:0]      fall_q,   fall_d;
  logic [WIDTH-1:0]      irq_en_q, irq_en_d;
  logic [GPIO_BUS_W-1:0] rdata_q,  rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  irq_q,    irq_d;

  gpio_reg_e             reg_sel;
  logic [WIDTH-1:0]      wmask;
  logic                  unused_bus_bits;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    gpio_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .pin_i    (gpio_port_in[i]),
      .stable_o (stable[i]),
      .rise_o   (rise_set[i]),
      .fall_o   (fall_set[i])
    );
  end

  assign reg_sel         = gpio_decode(addr);
  assign wmask           = wdata[WIDTH-1:0];
  assign unused_bus_bits = ^{addr[1:0], wdata};

  always_comb begin
    rise_d   = rise_q | rise_set;
    fall_d   = fall_q | fall_set;
    irq_en_d = irq_en_q;
    rdata_d  = rdata_q;
    rvalid_d = re;
    irq_d    = |((rise_q | fall_q) & irq_en_q);

    // A new edge in the same cycle as its W1C clear survives the clear.
    if (we) begin
      case (reg_sel)
        REG_RISE:  rise_d   = (rise_q & ~wmask) | rise_set;
        REG_FALL:  fall_d   = (fall_q & ~wmask) | fall_set;
        REG_IRQEN: irq_en_d = wmask;
        default:   ;
      endcase
    end

    // Read mux uses current register state, so a same-cycle write is not seen.
    if (re) begin
      case (reg_sel)
        REG_DATA:  rdata_d = GPIO_BUS_W'(stable);
        REG_RISE:  rdata_d = GPIO_BUS_W'(rise_q);
        REG_FALL:  rdata_d = GPIO_BUS_W'(fall_q);
        REG_IRQEN: rdata_d = GPIO_BUS_W'(irq_en_q);
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q   <= '0;
      fall_q   <= '0;
      irq_en_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      irq_en_q <= irq_en_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign irq    = irq_q;

endmodule
